// File: rtl/logic_acc_8b_if.sv
// logic_acc_8b_if: opcode/operand input handshake and registered result slot output.
interface logic_acc_8b_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_carry;
    modport master (
        output in_valid, in_op, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_carry
    );
    modport slave (
        input  in_valid, in_op, in_b, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_carry
    );
endinterface

// File: rtl/logic_acc_8b.sv
// logic_acc_8b: accumulator-based bitwise logic stage with a one-entry registered result slot.
module logic_acc_8b #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    logic_acc_8b_if.slave    bus,
    output logic [WIDTH-1:0] acc,
    output logic [7:0]       op_count
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t           state, state_nx;
    logic             accept, carry;
    logic [WIDTH-1:0] res;
    // a full slot draining this cycle frees room for a new result
    assign bus.in_ready  = (state == EMPTY) || bus.out_ready;
    assign bus.out_valid = (state == FULL);
    assign accept        = bus.in_valid && bus.in_ready;
    always_comb begin
        state_nx = state;
        state_nx = accept ? FULL : (bus.out_ready ? EMPTY : state);
    end
    always_comb begin
        res   = acc;
        carry = 1'b0;
        case (bus.in_op)
            3'b001: res = bus.in_b;
            3'b010: res = acc & bus.in_b;
            3'b011: res = acc | bus.in_b;
            3'b100: res = acc ^ bus.in_b;
            3'b101: res = ~acc;
            3'b110: {carry, res} = {acc, 1'b0};
            3'b111: {res, carry} = {1'b0, acc};
            default: res = acc;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= EMPTY;
        else state <= state_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            bus.out_data  <= '0;
            bus.out_zero  <= 1'b1;
            bus.out_carry <= 1'b0;
            op_count      <= '0;
        end else if (accept) begin
            acc           <= res;
            bus.out_data  <= res;
            bus.out_zero  <= (res == '0);
            bus.out_carry <= carry;
            op_count      <= op_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_logic_acc_8b.sv
// tb_logic_acc_8b: directed test-plan sequences plus randomized traffic against an arithmetic reference model.
module tb_logic_acc_8b;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] acc;
    logic [7:0] op_count;
    int         n_checks = 0;
    int         n_errs = 0;
    int         m_acc, m_data, m_zero, m_carry, m_valid, m_count;
    logic_acc_8b_if #(.WIDTH(8)) bus ();
    logic_acc_8b #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .acc      (acc),
        .op_count (op_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // result and carry from the opcode table, using plain integer arithmetic
    task automatic ref_op(input int op, input int a, input int b, output int r, output int c);
        c = 0;
        case (op)
            0: r = a;
            1: r = b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin r = (a * 2) % 256; c = a / 128; end
            default: begin r = a / 2; c = a % 2; end
        endcase
    endtask
    task automatic model_reset();
        m_acc = 0; m_data = 0; m_zero = 1; m_carry = 0; m_valid = 0; m_count = 0;
    endtask
    task automatic cycle(input logic v, input logic [2:0] op, input logic [7:0] b, input logic r);
        int res, c;
        @(negedge clk);
        bus.in_valid = v; bus.in_op = op; bus.in_b = b; bus.out_ready = r;
        #1 chk("in_ready", int'(bus.in_ready), int'(m_valid == 0 || r));
        @(posedge clk);
        if (v && (m_valid == 0 || r)) begin
            ref_op(int'(op), m_acc, int'(b), res, c);
            m_acc = res; m_data = res; m_zero = (res == 0); m_carry = c;
            m_valid = 1; m_count = (m_count + 1) % 256;
        end else if (m_valid != 0 && r) m_valid = 0;
        #1;
        chk("out_valid", int'(bus.out_valid), m_valid);
        chk("acc", int'(acc), m_acc);
        chk("op_count", int'(op_count), m_count);
        if (m_valid != 0) begin
            chk("out_data", int'(bus.out_data), m_data);
            chk("out_zero", int'(bus.out_zero), m_zero);
            chk("out_carry", int'(bus.out_carry), m_carry);
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = 3'b001; bus.in_b = 8'hFF; bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_acc", int'(acc), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_zero", int'(bus.out_zero), 1);
        chk("rst_carry", int'(bus.out_carry), 0);
        chk("rst_data", int'(bus.out_data), 0);
        chk("rst_count", int'(op_count), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        chk("rst_no_accept", int'(acc), 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
    endtask
    initial begin
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        model_reset();
        do_reset();
        // chained results through acc
        cycle(1, 3'b001, 8'h0F, 1); chk("chain0", int'(bus.out_data), 'h0F);
        cycle(1, 3'b010, 8'hF0, 1); chk("chain1", int'(bus.out_data), 'h00);
        chk("chain1_zero", int'(bus.out_zero), 1);
        cycle(1, 3'b001, 8'h3C, 1); chk("chain2", int'(bus.out_data), 'h3C);
        cycle(1, 3'b010, 8'h66, 1); chk("chain3", int'(bus.out_data), 'h24);
        chk("chain_count", int'(op_count), 4);
        // shifts, NOT, XOR, OR starting from 81
        cycle(1, 3'b001, 8'h81, 1);
        cycle(1, 3'b110, 8'h00, 1); chk("shl", int'(bus.out_data), 'h02); chk("shl_c", int'(bus.out_carry), 1);
        cycle(1, 3'b111, 8'h00, 1); chk("shr", int'(bus.out_data), 'h01); chk("shr_c", int'(bus.out_carry), 0);
        cycle(1, 3'b101, 8'h00, 1); chk("not", int'(bus.out_data), 'hFE);
        cycle(1, 3'b100, 8'hFF, 1); chk("xor", int'(bus.out_data), 'h01);
        cycle(1, 3'b011, 8'h80, 1); chk("or", int'(bus.out_data), 'h81); chk("or_c", int'(bus.out_carry), 0);
        // back-pressure then release
        cycle(1, 3'b001, 8'hAA, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 3'b010, 8'h0F, 0);
            chk("bp_data", int'(bus.out_data), 'hAA);
            chk("bp_acc", int'(acc), 'hAA);
        end
        cycle(1, 3'b010, 8'h0F, 1); chk("bp_release", int'(bus.out_data), 'h0A);
        cycle(0, 3'b000, 8'h00, 1); chk("drain_valid", int'(bus.out_valid), 0);
        chk("drain_acc", int'(acc), 'h0A);
        // reset mid-stream with a held result
        cycle(1, 3'b001, 8'h5A, 0);
        chk("pre_rst_valid", int'(bus.out_valid), 1);
        do_reset();
        // counter wrap
        for (int i = 0; i < 256; i++) cycle(1, 3'b000, 8'($urandom), 1);
        chk("wrap_count", int'(op_count), 0);
        chk("wrap_acc", int'(acc), 0);
        // random traffic
        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), ($urandom_range(0, 9) < 7));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
